// File: rtl/motors_step_sequencer.sv
// motors_step_sequencer
// Executes one motion command from the motors-control handshake: an optional
// pen-servo move (with settle delay) followed by concurrent X/Y stepping at a
// fixed rate. Both axes start together and run independently.
//
// Ports
//   clk                  system clock
//   reset                asynchronous active-low reset
//   pulse_num_x/_y       signed step counts; sign selects direction
//   servo_pos            requested pen position (1 = down)
//   trigger              start command, sampled only while rdy = 1
//   rdy                  idle and accepting a trigger
//   done                 one-cycle pulse at command completion
//   step_x/_y            step pulses to the stepper drivers
//   dir_x/_y             direction, 1 = negative count; held until next command
//   servo_out            pen position level to the servo PWM stage
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | rdy = 1, waiting for trigger
// SERVO_WAIT | pen moved, counting down the settle time
// STEPPING   | both axes stepping until their remaining counts reach 0
// DONE       | done = 1 for one cycle, then back to IDLE
module motors_step_sequencer #(
  parameter int PULSE_NUM_WIDTH = 16,
  parameter int STEP_PERIOD     = 1000,
  parameter int SERVO_SETTLE    = 1_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PULSE_NUM_WIDTH-1:0] pulse_num_x,
  input  logic [PULSE_NUM_WIDTH-1:0] pulse_num_y,
  input  logic                       servo_pos,
  input  logic                       trigger,
  output logic                       rdy,
  output logic                       done,
  output logic                       step_x,
  output logic                       step_y,
  output logic                       dir_x,
  output logic                       dir_y,
  output logic                       servo_out
);

  localparam int W     = PULSE_NUM_WIDTH;
  localparam int PH_W  = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int SET_W = $clog2(SERVO_SETTLE + 1);

  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(STEP_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_HALF     = PH_W'(STEP_PERIOD / 2);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SERVO_SETTLE);
  localparam logic [W-1:0]     ONE_W       = W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVO_WAIT,
    S_STEPPING,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]     cnt_x, cnt_y;
  logic [PH_W-1:0]  phase;
  logic [SET_W-1:0] settle_cnt;

  logic [W-1:0] mag_x, mag_y;
  logic         accept, servo_change, mag_zero;
  logic         fin_x, fin_y, phase_last;

  // Unsigned magnitude of a two's-complement count. The most-negative value
  // maps to 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v);
    return v[W-1] ? (~v + ONE_W) : v;
  endfunction

  assign mag_x        = magnitude(pulse_num_x);
  assign mag_y        = magnitude(pulse_num_y);
  assign mag_zero     = (mag_x == '0) && (mag_y == '0);
  assign accept       = (state == S_IDLE) && trigger;
  assign servo_change = (servo_pos != servo_out);
  assign phase_last   = (phase == PH_LAST);

  // An axis is finished once its count is 0, or it is on its last step and
  // the phase counter is about to wrap. Looking ahead lets DONE start in the
  // cycle right after the final decrement.
  assign fin_x = (cnt_x == '0) || ((cnt_x == ONE_W) && phase_last);
  assign fin_y = (cnt_y == '0) || ((cnt_y == ONE_W) && phase_last);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          if (servo_change)   state_nxt = S_SERVO_WAIT;
          else if (!mag_zero) state_nxt = S_STEPPING;
          else                state_nxt = S_DONE;
        end
      end
      S_SERVO_WAIT: begin
        if (settle_cnt <= SET_W'(1)) begin
          if ((cnt_x == '0) && (cnt_y == '0)) state_nxt = S_DONE;
          else                                state_nxt = S_STEPPING;
        end
      end
      S_STEPPING: begin
        if (fin_x && fin_y) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rdy    = (state == S_IDLE);
    done   = (state == S_DONE);
    step_x = 1'b0;
    step_y = 1'b0;
    if (state == S_STEPPING) begin
      step_x = (cnt_x != '0) && (phase < PH_HALF);
      step_y = (cnt_y != '0) && (phase < PH_HALF);
    end
  end

  // Datapath: counters, latched direction and pen position. One shared phase
  // counter serves both axes since they start together at the same rate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_x      <= '0;
      cnt_y      <= '0;
      phase      <= '0;
      settle_cnt <= '0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      servo_out  <= 1'b0;
    end else begin
      if (accept) begin
        cnt_x <= mag_x;
        cnt_y <= mag_y;
        dir_x <= pulse_num_x[W-1];
        dir_y <= pulse_num_y[W-1];
        phase <= '0;
        if (servo_change) begin
          servo_out  <= servo_pos;
          settle_cnt <= SETTLE_LOAD;
        end
      end else if (state == S_SERVO_WAIT) begin
        if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
      end else if (state == S_STEPPING) begin
        phase <= phase_last ? '0 : phase + PH_W'(1);
        if (phase_last) begin
          if (cnt_x != '0) cnt_x <= cnt_x - ONE_W;
          if (cnt_y != '0) cnt_y <= cnt_y - ONE_W;
        end
      end
    end
  end

endmodule

// File: tb/tb_motors_step_sequencer.sv
module tb_motors_step_sequencer;

  localparam int P = 4;
  localparam int S = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] px, py;
  logic        sp, trig;
  logic        rdy, done, step_x, step_y, dir_x, dir_y, servo_out;

  logic [7:0]  px8, py8;
  logic        sp8, trig8;
  logic        rdy8, done8, step_x8, step_y8, dir_x8, dir_y8, servo_out8;

  int  vectors = 0;
  int  miscompares = 0;
  bit  servo_model = 1'b0;

  always #5 clk = ~clk;

  motors_step_sequencer #(.PULSE_NUM_WIDTH(16), .STEP_PERIOD(P), .SERVO_SETTLE(S)) dut (
    .clk(clk), .reset(reset), .pulse_num_x(px), .pulse_num_y(py),
    .servo_pos(sp), .trigger(trig), .rdy(rdy), .done(done),
    .step_x(step_x), .step_y(step_y), .dir_x(dir_x), .dir_y(dir_y),
    .servo_out(servo_out)
  );

  // Narrow instance so the most-negative count runs to completion quickly.
  motors_step_sequencer #(.PULSE_NUM_WIDTH(8), .STEP_PERIOD(P), .SERVO_SETTLE(S)) dut8 (
    .clk(clk), .reset(reset), .pulse_num_x(px8), .pulse_num_y(py8),
    .servo_pos(sp8), .trigger(trig8), .rdy(rdy8), .done(done8),
    .step_x(step_x8), .step_y(step_y8), .dir_x(dir_x8), .dir_y(dir_y8),
    .servo_out(servo_out8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the falling edge of cycle t+1 of an accepted command. Expected
  // waveforms come from the command arithmetic: settle delay, then each axis
  // high for P/2 of every P cycles for N periods, done at t+1+settle+max(N)*P.
  task automatic monitor_cmd(input int x, input int y, input bit sv, input bit busy);
    int   nx, ny, settle, dk, j, werr, first_bad, rise_x, rise_y, done_k;
    logic prev_x, prev_y, ex_x, ex_y;
    nx = (x < 0) ? -x : x;
    ny = (y < 0) ? -y : y;
    settle = (sv != servo_model) ? S : 0;
    dk = 1 + settle + ((nx > ny) ? nx : ny) * P;
    werr = 0; first_bad = -1; rise_x = 0; rise_y = 0; done_k = -1;
    prev_x = 1'b0; prev_y = 1'b0;
    servo_model = sv;
    chk("dir_x", dir_x, (x < 0));
    chk("dir_y", dir_y, (y < 0));
    for (int k = 1; k <= dk + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (busy && k < dk) begin
        trig = 1'($urandom);
        px   = 16'($urandom);
        py   = 16'($urandom);
        sp   = 1'($urandom);
      end else begin
        trig = 1'b0;
      end
      j = k - 1 - settle;
      ex_x = (j >= 0) && (j < nx * P) && ((j % P) < P / 2);
      ex_y = (j >= 0) && (j < ny * P) && ((j % P) < P / 2);
      if ({step_x, step_y, done, rdy, servo_out, dir_x, dir_y} !==
          {ex_x, ex_y, (k == dk), (k == dk + 1), sv, (x < 0), (y < 0)}) begin
        werr++;
        if (first_bad < 0) first_bad = k;
      end
      if (step_x && !prev_x) rise_x++;
      if (step_y && !prev_y) rise_y++;
      prev_x = step_x;
      prev_y = step_y;
      if (done === 1'b1 && done_k < 0) done_k = k;
    end
    chk("pulses_x", rise_x, nx);
    chk("pulses_y", rise_y, ny);
    chk("done_cycle", done_k, dk);
    chk($sformatf("waveform(first bad k=%0d)", first_bad), werr, 0);
  endtask

  // Presents a command at the current falling edge; rdy must be high here.
  task automatic run_cmd(input int x, input int y, input bit sv, input bit busy);
    px = 16'(x); py = 16'(y); sp = sv; trig = 1'b1;
    chk("rdy_before", rdy, 1);
    @(posedge clk);
    @(negedge clk);
    monitor_cmd(x, y, sv, busy);
  endtask

  initial begin
    int rise, prev, dk8, done_k8, rise8x, rise8y, rdy8_bad;
    reset = 1'b0; trig = 1'b0; px = '0; py = '0; sp = 1'b0;
    trig8 = 1'b0; px8 = '0; py8 = '0; sp8 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", {rdy, done, step_x, step_y, dir_x, dir_y, servo_out}, 7'b1000000);
    reset = 1'b1;
    @(negedge clk);
    servo_model = 1'b0;

    // Basic two-axis command, mixed signs
    run_cmd(3, -2, 1'b0, 1'b0);

    // Pen down with zero-length move: settle only
    run_cmd(0, 0, 1'b1, 1'b0);

    // Zero command, servo unchanged, trigger held high across done
    px = '0; py = '0; sp = 1'b1; trig = 1'b1;
    chk("rdy_before_zero", rdy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("zero_done_t1", done, 1);
    chk("zero_rdy_t1", rdy, 0);
    px = 16'd2; py = 16'd0;
    @(posedge clk);
    @(negedge clk);
    chk("zero_rdy_t2", rdy, 1);
    chk("zero_done_t2", done, 0);
    @(posedge clk);
    @(negedge clk);
    monitor_cmd(2, 0, 1'b1, 1'b0);

    // Reset during the second step of x = 5
    px = 16'd5; py = '0; sp = 1'b1; trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_second_step", step_x, 1);
    #2 reset = 1'b0;
    #1 chk("rst_immediate", {rdy, done, step_x, step_y, dir_x, dir_y, servo_out}, 7'b1000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold", {rdy, done, step_x, step_y, dir_x, dir_y, servo_out}, 7'b1000000);
    end
    reset = 1'b1;
    servo_model = 1'b0;
    @(negedge clk);
    run_cmd(5, 1, 1'b0, 1'b0);

    // Most-negative count on the 16-bit instance: direction and first pulses
    px = 16'h8000; py = '0; sp = 1'b0; trig = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
    chk("neg_dir_x", dir_x, 1);
    rise = 0; prev = 0;
    for (int k = 1; k <= 10 * P; k++) begin
      if (k > 1) @(negedge clk);
      if (step_x && !prev) rise++;
      prev = int'(step_x);
    end
    chk("neg_pulses_10", rise, 10);
    chk("neg_still_busy", {rdy, done}, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    servo_model = 1'b0;
    @(negedge clk);

    // Most-negative count to completion on the 8-bit instance (-128)
    px8 = 8'h80; py8 = 8'd3; sp8 = 1'b0; trig8 = 1'b1;
    chk("rdy8_before", rdy8, 1);
    @(posedge clk);
    @(negedge clk);
    trig8 = 1'b0;
    chk("neg8_dir", {dir_x8, dir_y8}, 2'b10);
    dk8 = 1 + 128 * P;
    done_k8 = -1; rise8x = 0; rise8y = 0; rdy8_bad = 0;
    prev = 0;
    for (int k = 1; k <= dk8 + 1; k++) begin
      logic py_prev;
      if (k > 1) @(negedge clk);
      if (step_x8 && !prev[0]) rise8x++;
      py_prev = prev[1];
      if (step_y8 && !py_prev) rise8y++;
      prev = {30'd0, step_y8, step_x8};
      if (done8 === 1'b1 && done_k8 < 0) done_k8 = k;
      if (k <= dk8 && rdy8 !== 1'b0) rdy8_bad++;
    end
    chk("neg8_pulses_x", rise8x, 128);
    chk("neg8_pulses_y", rise8y, 3);
    chk("neg8_done_cycle", done_k8, dk8);
    chk("neg8_rdy_low", rdy8_bad, 0);
    chk("neg8_rdy_after", rdy8, 1);

    // Random commands, back to back; odd ones get trigger noise while busy
    for (int i = 0; i < 12; i++) begin
      int x, y;
      x = int'($urandom_range(0, 12)) - 6;
      y = int'($urandom_range(0, 12)) - 6;
      run_cmd(x, y, 1'($urandom), i[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motors_step_sequencer.md
# motors_step_sequencer

Executes one motion command presented on the motors-control handshake: pen servo position plus signed X/Y step counts. Sits directly downstream of the op-handler output chooser and consumes the selected handshake (pulse_num_x, pulse_num_y, servo_pos, trigger; returns rdy, done). Drives step/direction to both stepper drivers and the pen-servo position level. Both axes step concurrently at a fixed rate.

## Interface
- PULSE_NUM_WIDTH, 16: width of signed two's-complement step counts.
- STEP_PERIOD, 1000: clock cycles per step pulse; even, ≥ 4.
- SERVO_SETTLE, 1_000_000: cycles waited after a servo position change; ≥ 1.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- pulse_num_x  in  PULSE_NUM_WIDTH  signed X step count; sign gives direction.
- pulse_num_y  in  PULSE_NUM_WIDTH  signed Y step count.
- servo_pos  in  1  requested pen position (1 = down, 0 = up).
- trigger  in  1  start command; sampled only while rdy = 1.
- rdy  out  1  idle, accepting a trigger.
- done  out  1  one-cycle pulse at command completion.
- step_x, step_y  out  1  step pulses to drivers.
- dir_x, dir_y  out  1  direction (1 = negative count).
- servo_out  out  1  pen position level to servo PWM stage.

## Operation
- States: IDLE, SERVO_WAIT, STEPPING, DONE.
- IDLE: rdy = 1. On trigger = 1: latch |pulse_num_x|, |pulse_num_y| into PULSE_NUM_WIDTH-bit unsigned counters (most-negative value gives magnitude 2^(W-1), no overflow); latch dir_x/dir_y = sign bits; rdy drops next cycle.
  - servo_pos ≠ servo_out: servo_out ← servo_pos, settle counter ← SERVO_SETTLE, go SERVO_WAIT.
  - servo unchanged, either magnitude nonzero: go STEPPING.
  - servo unchanged, both magnitudes zero: go DONE.
- SERVO_WAIT: decrement settle counter; on reaching 0 go STEPPING, or DONE if both magnitudes are zero.
- STEPPING: each axis with remaining count > 0 runs a phase counter 0..STEP_PERIOD-1.
  - step = 1 for phases 0..STEP_PERIOD/2-1, else 0.
  - At phase STEP_PERIOD-1 the remaining count decrements.
  - An axis at 0 holds step = 0.
  - Axes are independent and start in the same cycle.
  - Leave for DONE in the cycle after both counts reach 0.
- DONE: done = 1, rdy = 0 for exactly one cycle, then IDLE.
- dir_x/dir_y hold their latched values until the next accepted trigger, including after done. servo_out holds its value between commands.
- trigger while rdy = 0 is ignored; inputs are not re-sampled mid-command.

## Timing
- Reset values (asserted asynchronously, held while reset = 0): state IDLE, rdy = 1, done = 0, step_x = step_y = 0, dir_x = dir_y = 0, servo_out = 0, all counters 0.
- Reset mid-command aborts immediately: step outputs fall the same instant, no done is issued, and servo_out returns to 0.
- Trigger accepted at edge t: rdy = 0 from t+1. Without a servo change, the first step rising edge is at t+1.
- Completion, servo unchanged: done high in the cycle starting at t+1+max(Nx,Ny)·STEP_PERIOD, where N = magnitude.
- Servo change: add SERVO_SETTLE cycles before the first step; servo_out toggles at t+1.
- Zero-length command, servo unchanged: done at t+1, rdy = 1 at t+2.
- rdy returns in the cycle after done. A trigger in that cycle is accepted, allowing back-to-back commands with one idle cycle.

## Test plan
Bench parameters: STEP_PERIOD = 4, SERVO_SETTLE = 8, PULSE_NUM_WIDTH = 16.
- Command x = 3, y = -2, servo 0 → step_x shows 3 pulses (2 high / 2 low) and step_y 2 pulses; dir_x = 0, dir_y = 1; done exactly 12 cycles after t+1; rdy low throughout.
- Command x = 0, y = 0, servo 1 from reset → servo_out = 1 at t+1, no step pulses, done 8 cycles later, then rdy = 1.
- Command x = -32768, y = 0 → dir_x = 1, exactly 32768 step_x pulses, done at t+1+131072.
- Zero command with servo unchanged → done at t+1, rdy at t+2; a second trigger held high throughout is accepted only at t+2.
- Reset pulled low during the second step of x = 5 → all outputs at reset values immediately, no done pulse; a fresh command afterward executes normally.
- trigger pulsed repeatedly while busy with different pulse_num values → ignored; the original counts complete unchanged.
